// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the SRAM-like
// memory port (slave): request/address phase plus response/data phase.
interface mem_access_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one outstanding bus transaction,
// store alignment/strobes, load extraction, result held until WB takes it.
module mem_access_ctrl #(
  parameter bit STALL_ON_STORE = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_valid,
  input  logic [31:0] exe_pc,
  input  logic [31:0] exe_addr,
  input  logic        exe_load,
  input  logic        exe_store,
  input  logic [1:0]  exe_size,
  input  logic        exe_sign,
  input  logic [31:0] exe_wdata,
  input  logic [4:0]  exe_dst,
  input  logic        exe_except,
  input  logic        mem_flush,
  input  logic        wb_allowin,
  output logic        mem_allowin,
  mem_access_ctrl_if.master bus,
  output logic        mem_valid,
  output logic [31:0] mem_pc,
  output logic [4:0]  mem_dst,
  output logic        mem_except,
  output logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  dst;
    logic [1:0]  size;
    logic        load;
    logic        store;
    logic        sign;
    logic        except;
  } mem_op_t;

  state_t      state, state_nxt;
  mem_op_t     op;
  logic [31:0] rdata_q;
  logic        accept, is_mem, capture;
  logic [3:0]  wstrb_w;
  logic [31:0] wdata_w, load_ext;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;

  assign is_mem = (exe_load | exe_store) & ~exe_except;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt    = state;
    mem_allowin  = 1'b0;
    bus.data_req = 1'b0;
    mem_valid    = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: mem_allowin = 1'b1;
      REQ: begin
        bus.data_req = ~mem_flush;
        // Retracting the request before addr_ok is legal on this bus
        if (mem_flush) state_nxt = IDLE;
        else if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            state_nxt = DONE;
            capture   = 1'b1;
          end else if (op.store && !STALL_ON_STORE) state_nxt = DONE;
          else state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.data_data_ok) begin
          state_nxt = mem_flush ? IDLE : DONE;
          capture   = ~mem_flush;
        end else if (mem_flush) state_nxt = DISCARD;
      end
      DONE: begin
        mem_valid   = 1'b1;
        mem_allowin = wb_allowin;
        if (mem_flush) state_nxt = IDLE;
        else if (wb_allowin) state_nxt = IDLE;
      end
      // Drain the killed transaction's response before starting another
      DISCARD: if (bus.data_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    accept = exe_valid & mem_allowin & ~mem_flush;
    if (accept) state_nxt = is_mem ? REQ : DONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op      <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      op      <= '{pc: exe_pc, addr: exe_addr, wdata: exe_wdata, dst: exe_dst,
                   size: exe_size, load: exe_load, store: exe_store,
                   sign: exe_sign, except: exe_except};
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= op.load ? load_ext : 32'h0;
    end
  end

  always_comb begin
    wstrb_w = 4'b1111;
    wdata_w = op.wdata;
    case (op.size)
      2'd0: begin
        wstrb_w = 4'b0001 << op.addr[1:0];
        wdata_w = {4{op.wdata[7:0]}};
      end
      2'd1: begin
        wstrb_w = op.addr[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{op.wdata[15:0]}};
      end
      default: ;
    endcase
    if (!op.store) wstrb_w = 4'b0000;
  end

  assign rd_b = bus.data_rdata[{op.addr[1:0], 3'b000} +: 8];
  assign rd_h = bus.data_rdata[{op.addr[1], 4'b0000} +: 16];

  always_comb begin
    case (op.size)
      2'd0:    load_ext = {{24{op.sign & rd_b[7]}}, rd_b};
      2'd1:    load_ext = {{16{op.sign & rd_h[15]}}, rd_h};
      default: load_ext = bus.data_rdata;
    endcase
  end

  assign bus.data_wr    = op.store;
  assign bus.data_size  = op.size;
  assign bus.data_addr  = op.addr;
  assign bus.data_wstrb = wstrb_w;
  assign bus.data_wdata = wdata_w;

  assign mem_pc     = op.pc;
  assign mem_dst    = op.dst;
  assign mem_except = op.except;
  assign mem_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a stalling-store instance and a
// fire-and-forget-store instance sharing the EXE-side fields.
module tb_mem_access_ctrl;
  logic        clk, resetn;
  logic        exe_valid, exe_valid0;
  logic [31:0] exe_pc, exe_addr, exe_wdata;
  logic        exe_load, exe_store, exe_sign, exe_except;
  logic [1:0]  exe_size;
  logic [4:0]  exe_dst;
  logic        mem_flush, wb_allowin;
  logic        mem_allowin, mem_valid, mem_except;
  logic [31:0] mem_pc, mem_rdata;
  logic [4:0]  mem_dst;
  logic        mem_allowin0, mem_valid0, mem_except0;
  logic [31:0] mem_pc0, mem_rdata0;
  logic [4:0]  mem_dst0;

  int checks = 0;
  int failures = 0;

  mem_access_ctrl_if bus ();
  mem_access_ctrl_if bus0 ();

  mem_access_ctrl #(.STALL_ON_STORE(1'b1)) dut (
    .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .exe_pc(exe_pc),
    .exe_addr(exe_addr), .exe_load(exe_load), .exe_store(exe_store),
    .exe_size(exe_size), .exe_sign(exe_sign), .exe_wdata(exe_wdata),
    .exe_dst(exe_dst), .exe_except(exe_except), .mem_flush(mem_flush),
    .wb_allowin(wb_allowin), .mem_allowin(mem_allowin), .bus(bus),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_dst(mem_dst),
    .mem_except(mem_except), .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.STALL_ON_STORE(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .exe_valid(exe_valid0), .exe_pc(exe_pc),
    .exe_addr(exe_addr), .exe_load(exe_load), .exe_store(exe_store),
    .exe_size(exe_size), .exe_sign(exe_sign), .exe_wdata(exe_wdata),
    .exe_dst(exe_dst), .exe_except(exe_except), .mem_flush(mem_flush),
    .wb_allowin(wb_allowin), .mem_allowin(mem_allowin0), .bus(bus0),
    .mem_valid(mem_valid0), .mem_pc(mem_pc0), .mem_dst(mem_dst0),
    .mem_except(mem_except0), .mem_rdata(mem_rdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks sample 1 unit later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [31:0] addr, input logic ld,
                        input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] wd, input logic [4:0] dst, input logic exc);
    exe_pc = pc; exe_addr = addr; exe_load = ld; exe_store = st; exe_size = sz;
    exe_sign = sg; exe_wdata = wd; exe_dst = dst; exe_except = exc;
  endtask

  task automatic load_rt(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] rd, input logic [31:0] exp);
    set_op(32'h180, addr, 1'b1, 1'b0, sz, sg, 32'h0, 5'd2, 1'b0);
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata = rd;
    tick();
    bus.data_data_ok = 1'b0;
    bus.data_rdata = 32'h0;
    #1;
    chk(tag, mem_rdata, exp);
    tick();
  endtask

  initial begin
    resetn = 1'b0; exe_valid = 1'b0; exe_valid0 = 1'b0;
    set_op(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 5'd0, 1'b0);
    mem_flush = 1'b0; wb_allowin = 1'b1;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    bus0.data_addr_ok = 1'b0; bus0.data_data_ok = 1'b0; bus0.data_rdata = 32'h0;
    #3;
    chk("rst_allowin", mem_allowin, 1);
    chk("rst_req", bus.data_req, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_addr", bus.data_addr, 0);
    chk("rst_wstrb", bus.data_wstrb, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // LW, addr_ok one cycle after req, data_ok two cycles after that
    set_op(32'h100, 32'h1000_0004, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 5'd3, 1'b0);
    exe_valid = 1'b1;
    #1 chk("lw_allowin_idle", mem_allowin, 1);
    tick();
    exe_valid = 1'b0;
    #1;
    chk("lw_req", bus.data_req, 1);
    chk("lw_addr", bus.data_addr, 32'h1000_0004);
    chk("lw_wr", bus.data_wr, 0);
    chk("lw_wstrb", bus.data_wstrb, 0);
    chk("lw_size", bus.data_size, 2);
    chk("lw_allowin_req", mem_allowin, 0);
    tick();
    bus.data_addr_ok = 1'b1;
    #1 chk("lw_req_held", bus.data_req, 1);
    tick();
    bus.data_addr_ok = 1'b0;
    #1;
    chk("lw_req_wait", bus.data_req, 0);
    chk("lw_allowin_wait", mem_allowin, 0);
    tick();
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_valid_early", mem_valid, 0);
    chk("lw_allowin_dok", mem_allowin, 0);
    tick();
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    #1;
    chk("lw_valid", mem_valid, 1);
    chk("lw_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("lw_pc", mem_pc, 32'h100);
    chk("lw_dst", mem_dst, 3);
    chk("lw_except", mem_except, 0);
    tick();
    #1 chk("lw_valid_drop", mem_valid, 0);

    // Load extraction
    load_rt("lb_sign", 32'h1000_0003, 2'd0, 1'b1, 32'h8012_3456, 32'hFFFF_FF80);
    load_rt("lbu", 32'h1000_0003, 2'd0, 1'b0, 32'h8012_3456, 32'h0000_0080);
    load_rt("lh_sign", 32'h1000_0002, 2'd1, 1'b1, 32'h8012_3456, 32'hFFFF_8012);
    load_rt("lhu_lo", 32'h1000_0000, 2'd1, 1'b0, 32'h8012_F456, 32'h0000_F456);
    load_rt("lb_b1", 32'h1000_0001, 2'd0, 1'b1, 32'h8012_3456, 32'h0000_0034);

    // SH on the stalling instance waits for data_ok
    set_op(32'h200, 32'h2000_0002, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_ABCD, 5'd0, 1'b0);
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    #1;
    chk("sh_req", bus.data_req, 1);
    chk("sh_wr", bus.data_wr, 1);
    chk("sh_wstrb", bus.data_wstrb, 4'b1100);
    chk("sh_wdata", bus.data_wdata, 32'hABCD_ABCD);
    chk("sh_size", bus.data_size, 1);
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    #1 chk("sh_wait_valid", mem_valid, 0);
    bus.data_data_ok = 1'b1;
    tick();
    bus.data_data_ok = 1'b0;
    #1;
    chk("sh_done_valid", mem_valid, 1);
    chk("sh_rdata", mem_rdata, 0);
    tick();

    // Same SH on the instance that completes stores at addr_ok
    exe_valid0 = 1'b1;
    tick();
    exe_valid0 = 1'b0;
    #1;
    chk("sh0_req", bus0.data_req, 1);
    chk("sh0_wstrb", bus0.data_wstrb, 4'b1100);
    bus0.data_addr_ok = 1'b1;
    tick();
    bus0.data_addr_ok = 1'b0;
    #1 chk("sh0_done_on_addr_ok", mem_valid0, 1);
    tick();
    bus0.data_data_ok = 1'b1;
    tick();
    bus0.data_data_ok = 1'b0;
    #1;
    chk("sh0_late_dok_valid", mem_valid0, 0);
    chk("sh0_late_dok_allowin", mem_allowin0, 1);

    // SB strobes, then flush while in REQ
    set_op(32'h204, 32'h2000_0001, 1'b0, 1'b1, 2'd0, 1'b0, 32'h1234_5677, 5'd0, 1'b0);
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    #1;
    chk("sb_wstrb", bus.data_wstrb, 4'b0010);
    chk("sb_wdata", bus.data_wdata, 32'h7777_7777);
    mem_flush = 1'b1;
    #1 chk("req_flush_drop", bus.data_req, 0);
    tick();
    mem_flush = 1'b0;
    #1;
    chk("req_flush_idle", mem_allowin, 1);
    chk("req_flush_valid", mem_valid, 0);

    // Flush in WAIT, response arrives three cycles later and is dropped
    set_op(32'h300, 32'h1000_0010, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 5'd5, 1'b0);
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    mem_flush = 1'b1;
    tick();
    mem_flush = 1'b0;
    set_op(32'h304, 32'h1000_0008, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 5'd7, 1'b0);
    exe_valid = 1'b1;
    #1;
    chk("disc_allowin1", mem_allowin, 0);
    chk("disc_req", bus.data_req, 0);
    chk("disc_valid", mem_valid, 0);
    tick();
    #1 chk("disc_allowin2", mem_allowin, 0);
    tick();
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1111_1111;
    #1 chk("disc_allowin3", mem_allowin, 0);
    tick();
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    #1;
    chk("disc_idle_allowin", mem_allowin, 1);
    chk("disc_idle_valid", mem_valid, 0);
    tick();
    exe_valid = 1'b0;
    #1;
    chk("post_disc_req", bus.data_req, 1);
    chk("post_disc_addr", bus.data_addr, 32'h1000_0008);
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h2222_2222;
    tick();
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    #1;
    chk("post_disc_rdata", mem_rdata, 32'h2222_2222);
    chk("post_disc_pc", mem_pc, 32'h304);
    chk("post_disc_dst", mem_dst, 7);
    tick();

    // Held in DONE by WB, then zero-bubble handoff to the next load
    set_op(32'h400, 32'h1000_0020, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 5'd8, 1'b0);
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    bus.data_addr_ok = 1'b1;
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hA5A5_A5A5;
    wb_allowin = 1'b0;
    tick();
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    set_op(32'h404, 32'h1000_0024, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 5'd9, 1'b0);
    exe_valid = 1'b1;
    #1;
    chk("hold_valid", mem_valid, 1);
    chk("hold_stall", mem_allowin, 0);
    tick();
    #1;
    chk("hold_valid2", mem_valid, 1);
    chk("hold_pc", mem_pc, 32'h400);
    chk("hold_rdata", mem_rdata, 32'hA5A5_A5A5);
    chk("hold_req", bus.data_req, 0);
    wb_allowin = 1'b1;
    #1 chk("b2b_allowin", mem_allowin, 1);
    tick();
    exe_valid = 1'b0;
    #1;
    chk("b2b_req", bus.data_req, 1);
    chk("b2b_addr", bus.data_addr, 32'h1000_0024);
    chk("b2b_valid", mem_valid, 0);
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5A5A_0000;
    tick();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    #1;
    chk("same_cycle_valid", mem_valid, 1);
    chk("same_cycle_rdata", mem_rdata, 32'h5A5A_0000);
    chk("same_cycle_pc", mem_pc, 32'h404);
    tick();

    // Excepting load skips the bus; flush in DONE kills it
    set_op(32'h500, 32'h1000_0001, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 5'd4, 1'b1);
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    #1;
    chk("exc_req", bus.data_req, 0);
    chk("exc_valid", mem_valid, 1);
    chk("exc_flag", mem_except, 1);
    chk("exc_rdata", mem_rdata, 0);
    wb_allowin = 1'b0; mem_flush = 1'b1;
    tick();
    mem_flush = 1'b0; wb_allowin = 1'b1;
    #1 chk("done_flush_valid", mem_valid, 0);
    bus.data_data_ok = 1'b1;
    tick();
    bus.data_data_ok = 1'b0;
    #1;
    chk("idle_dok_valid", mem_valid, 0);
    chk("idle_dok_allowin", mem_allowin, 1);

    // Reset in the middle of a request
    set_op(32'h600, 32'h1000_0030, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 5'd6, 1'b0);
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    #1 chk("midrst_req_before", bus.data_req, 1);
    resetn = 1'b0;
    #1;
    chk("midrst_req", bus.data_req, 0);
    chk("midrst_allowin", mem_allowin, 1);
    chk("midrst_pc", mem_pc, 0);
    tick();
    resetn = 1'b1;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h3333_3333;
    tick();
    bus.data_data_ok = 1'b0;
    #1;
    chk("midrst_late_valid", mem_valid, 0);
    chk("midrst_late_rdata", mem_rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage data-memory access controller, directly downstream of the EXE stage. Accepts each instruction leaving EXE: ALU-computed address, load/store controls, store data, destination and exception flag. For loads and stores it runs one SRAM-like transaction on the data bus (req/addr_ok/data_ok), aligns store data, builds byte strobes and extends load data. It holds the completed result until WB accepts it, and stalls EXE while a transaction is in flight.

Parameters:
STALL_ON_STORE, 1, 1: a store completes on data_ok; 0: a store completes on addr_ok.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
exe_valid  in  1  EXE holds an instruction ready to enter MEM
exe_pc  in  32  instruction PC
exe_addr  in  32  ALU result, used as the memory address
exe_load  in  1  instruction is a load
exe_store  in  1  instruction is a store
exe_size  in  2  access size: 0 byte, 1 half, 2 word
exe_sign  in  1  sign-extend load data
exe_wdata  in  32  store data, right-aligned
exe_dst  in  5  destination register
exe_except  in  1  EXE already flagged an exception (includes misalignment)
mem_flush  in  1  kill the MEM-stage instruction
wb_allowin  in  1  WB can accept this cycle
mem_allowin  out  1  controller accepts from EXE this cycle
data_req  out  1  bus request
data_wr  out  1  1 = write
data_size  out  2  equals latched exe_size
data_addr  out  32  latched exe_addr
data_wstrb  out  4  byte strobes (0 for loads)
data_wdata  out  32  replicated store data
data_addr_ok  in  1  bus accepted the request
data_data_ok  in  1  response / write completion
data_rdata  in  32  read data
mem_valid  out  1  result valid toward WB
mem_pc  out  32  latched PC
mem_dst  out  5  latched destination
mem_except  out  1  latched exception flag
mem_rdata  out  32  extended load data (0 for non-loads)

Behaviour:
- Reset: state IDLE; all registered outputs 0; data_req 0; mem_allowin 1.
- States: IDLE, REQ, WAIT, DONE, DISCARD. At most one outstanding transaction.
- Accept rule: accept = exe_valid & mem_allowin & ~mem_flush.
  - mem_allowin = (IDLE) | (DONE & wb_allowin).
  - On accept, latch all exe_* fields.
  - If (exe_load | exe_store) & ~exe_except, go to REQ.
  - Otherwise go to DONE; no bus activity; mem_rdata = 0.
- REQ:
  - data_req = ~mem_flush.
  - data_addr_ok & ~mem_flush: go to WAIT. For a store with STALL_ON_STORE=0, go to DONE instead.
  - data_addr_ok & data_data_ok in the same cycle: go directly to DONE.
  - mem_flush: go to IDLE. A request is retracted before addr_ok, which the bus permits.
- WAIT:
  - data_data_ok: capture the extended data into mem_rdata and go to DONE. mem_valid rises the next cycle.
  - mem_flush without data_data_ok: go to DISCARD.
  - mem_flush with data_data_ok: go to IDLE.
- DISCARD: data_req 0, mem_allowin 0; go to IDLE on data_data_ok; response dropped.
- DONE:
  - mem_valid = 1.
  - On wb_allowin, leave: to REQ/DONE if an accept occurs the same cycle (zero bubble), else IDLE.
  - mem_flush: go to IDLE; mem_valid drops the next cycle.
- Store strobes and data:
  - Byte: wstrb = 1 << addr[1:0]; wdata = 4 copies of wdata[7:0].
  - Half: wstrb = addr[1] ? 1100 : 0011; wdata = 2 copies of wdata[15:0].
  - Word: wstrb = 1111; wdata as given.
- Load extraction:
  - Byte: rdata[8*addr[1:0] +: 8].
  - Half: rdata[16*addr[1] +: 16].
  - Sign- or zero-extended per exe_sign.
- Bus output stability: data_addr, data_wr, data_size, data_wstrb and data_wdata are stable throughout REQ.
- EXE stall: EXE stalls whenever exe_valid & ~mem_allowin.
- Reset mid-transaction: returns to IDLE immediately; any late data_ok after reset is ignored in IDLE.
- data_data_ok in IDLE or DONE is a protocol error; it is ignored.

Test Plan:
1. LW at 0x1000_0004; addr_ok 1 cycle after req; data_ok 2 cycles later with rdata 0xDEADBEEF -> mem_valid the cycle after data_ok, mem_rdata 0xDEADBEEF; mem_allowin 0 throughout.
2. LB at 0x1000_0003 with rdata 0x80123456 -> mem_rdata 0xFFFFFF80; same access as LBU -> 0x00000080; LH at 0x1000_0002 signed -> 0xFFFF8012.
3. SH at 0x2000_0002 with exe_wdata 0x0000ABCD -> data_wr 1, wstrb 1100, data_wdata 0xABCDABCD. With STALL_ON_STORE=0 -> DONE on addr_ok without waiting for data_ok.
4. Flush in WAIT, data_ok arrives 3 cycles later -> mem_valid never set, mem_allowin 0 until that data_ok, then an LW is accepted normally and returns its own data.
5. Back-to-back: DONE with wb_allowin=1 and a new exe_valid load -> accepted the same cycle, data_req the next cycle. With wb_allowin=0 -> held in DONE, outputs stable, EXE stalled.
6. Load with exe_except=1 -> data_req never asserts; mem_valid and mem_except 1 the next cycle; flush in REQ before addr_ok -> data_req drops the same cycle, state returns to IDLE.
